// File: rtl/count_seq_ctrl.sv
// Run-control counter feeding a 4-bit magnitude comparator.
// Runs cnt_a up or down toward lim_b and stops a run on the comparator's EQ, overshoot or fault result.
module count_seq_ctrl #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_LIMIT = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load_lim,
    input  logic [WIDTH-1:0] lim_in,
    input  logic             cmp_g,
    input  logic             cmp_eq,
    input  logic             cmp_l,
    output logic [WIDTH-1:0] cnt_a,
    output logic [WIDTH-1:0] lim_b,
    output logic             busy,
    output logic             done,
    output logic             ovr,
    output logic             fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             dir_q, dir_d;
    logic             ovr_q, ovr_d;
    logic             fault_q, fault_d;

    logic             cmp_onehot;
    logic             overshoot;

    assign cmp_onehot = $onehot({cmp_g, cmp_eq, cmp_l});
    // Past the limit means above it when counting up, below it when counting down.
    assign overshoot  = dir_q ? cmp_l : cmp_g;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = load_lim ? lim_in : lim_q;
        dir_d   = dir_q;
        ovr_d   = ovr_q;
        fault_d = fault_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = dir ? '1 : '0;
                    dir_d   = dir;
                    ovr_d   = 1'b0;
                    fault_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Terminal conditions outrank stop so a run at its limit always finishes.
                if (!cmp_onehot) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end else if (cmp_eq) begin
                    state_d = S_DONE;
                end else if (overshoot) begin
                    state_d = S_DONE;
                    ovr_d   = 1'b1;
                end else if (stop) begin
                    state_d = S_HOLD;
                end else if (dir_q) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lim_q   <= RESET_LIMIT;
            dir_q   <= 1'b0;
            ovr_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            ovr_q   <= ovr_d;
            fault_q <= fault_d;
        end
    end

    assign cnt_a = cnt_q;
    assign lim_b = lim_q;
    assign busy  = (state_q == S_RUN) || (state_q == S_HOLD);
    assign done  = (state_q == S_DONE);
    assign ovr   = ovr_q;
    assign fault = fault_q;

endmodule
